trace_collector: RTL and testbench
==================================

# trace_collector

Capture-side companion to the pipelined `mips` core. It snoops the core's register-file write port (WB stage) and data-memory write port (MEM stage), and packs each architectural write event into a single program-ordered stream. The stream is buffered in a small FIFO and handed to a downstream checker or logger over a valid/ready handshake. It is the consumer end of the trace the core produces, so benches compare against an expected trace instead of scraping `$display` output.

## Interface
Parameters:
- `DEPTH`, 8, FIFO entries; power of two, ≥ 2.
- `CNT_W`, 16, width of the drop counter.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `grf_we`  in  1  register write this cycle (WB stage).
- `grf_pc`  in  32  PC of the writing instruction.
- `grf_addr`  in  5  destination register.
- `grf_wd`  in  32  write data.
- `dm_we`  in  1  memory write this cycle (MEM stage).
- `dm_pc`  in  32  PC of the storing instruction.
- `dm_addr`  in  32  byte address, word-aligned by the core.
- `dm_be`  in  4  byte enables.
- `dm_wd`  in  32  write data, already lane-shifted.
- `out_valid`  out  1  head entry available.
- `out_ready`  in  1  consumer accepts head.
- `out_kind`  out  1  0 = GRF event, 1 = DM event.
- `out_pc`  out  32  event PC.
- `out_addr`  out  32  GRF: zero-extended register number; DM: byte address.
- `out_be`  out  4  GRF: 4'b1111; DM: `dm_be`.
- `out_data`  out  32  write data.
- `overflow`  out  1  sticky; set on the first dropped event.
- `drop_cnt`  out  `CNT_W`  dropped-event count, saturating.

## Operation
- Event filter:
  - A GRF event is `grf_we && grf_addr != 0`. Writes to `$0` are discarded silently and are not counted as drops.
  - A DM event is `dm_we && dm_be != 0`.
- Ordering: a WB event is older than a MEM event in the same cycle. When both are present, the GRF entry is pushed first and the DM entry second.
- Pop: occurs when `out_valid && out_ready`.
- Free space: `free = DEPTH - count + pop`. A pop in the same cycle frees its slot for that cycle's pushes.
- Push decision:
  - 0 events: no push.
  - 1 event, `free ≥ 1`: push it.
  - 2 events, `free ≥ 2`: push both, GRF first.
  - 2 events, `free == 1`: push GRF, drop DM.
  - Any event with `free == 0`: drop it.
- Each drop increments `drop_cnt` by 1 (2 if both events are dropped) and saturates at all-ones. Any drop sets `overflow`, which clears only on reset.
- FIFO: circular buffer with read/write pointers of `log2(DEPTH)` bits that wrap modulo `DEPTH`. `count` has `log2(DEPTH)+1` bits. A dual push advances the write pointer by 2.
- Output: show-ahead. The `out_*` fields present the head entry whenever `count != 0`. Fields hold stable while `out_valid && !out_ready`. When `out_valid == 0`, field values are don't-care but are driven to 0.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert from the top level):
  - Pointers, `count`, `out_valid`, `overflow`, `drop_cnt` and every `out_*` field go to 0.
  - Buffered entries are lost.
  - Reset asserted mid-handshake aborts the handshake; there is no partial pop.
- Latency: an event sampled at edge N gives `out_valid = 1` after edge N, provided the FIFO was empty. There is no bypass; the stream is always registered.
- Throughput: 2 pushes and 1 pop per cycle. Sustained dual events with `out_ready = 1` overflow after about `DEPTH` cycles; this is expected.
- Full FIFO with pop and one event in the same cycle: the event is accepted and `count` is unchanged.
- Empty FIFO with an event: no pop is possible in that cycle; the event is visible next cycle.
- `out_ready` may toggle freely. No combinational path from `out_ready` to `out_valid`. The only path from `out_ready` to push acceptance is through `free`.

## Structure
- Package `trace_pkg`:
  - `trace_kind_e` {`TR_GRF`, `TR_DM`}.
  - Packed struct `trace_entry_t` {kind, pc[31:0], addr[31:0], be[3:0], data[31:0]}, 101 bits.
  - Constant `TR_BE_FULL = 4'b1111`.
- Sub-module `trace_fifo`: a dual-push, single-pop circular FIFO of `trace_entry_t`, parameterised on `DEPTH`. It exports `count` and `free`.
- The top level holds:
  - the event filter,
  - the push ordering and drop arbitration,
  - the saturating counter,
  - the sticky flag.

## Test plan
- Single GRF event: `grf_we = 1`, addr 8, pc 0x3000, wd 0x1234, `out_ready = 1`. Next cycle `out_valid = 1` with kind 0, addr 8, be 4'hF, data 0x1234. Popped in one cycle; `drop_cnt = 0`.
- Same-cycle GRF + DM with `out_ready = 1`:
  - GRF at pc 0x3004, DM at pc 0x3008 with addr 0x10, be 4'b0011.
  - GRF entry pops first, DM entry second, on consecutive cycles.
- `$0` write and zero byte-enable store: both are ignored. `out_valid` stays 0 and `drop_cnt` stays 0.
- Backpressure, `DEPTH = 8`, `out_ready = 0`:
  - 8 GRF events fill the FIFO. A 9th GRF event plus a DM event in one cycle gives `drop_cnt = 2` and `overflow = 1`.
  - Raising `out_ready` then drains exactly the 8 original entries in order.
- Full FIFO with one free slot after a pop, plus dual events: GRF is accepted, DM is dropped, `drop_cnt` increments by 1, and `count` stays 8.
- Reset mid-stream: assert `reset = 0` with 5 entries queued. `out_valid`, `count`, `overflow` and `drop_cnt` go to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/trace_pkg.sv
// Shared types for the trace capture path: event kind, packed trace entry
// and the byte-enable value reported for register-file writes.
package trace_pkg;

    typedef enum logic {
        TR_GRF = 1'b0,
        TR_DM  = 1'b1
    } trace_kind_e;

    // 1 + 32 + 32 + 4 + 32 = 101 bits
    typedef struct packed {
        trace_kind_e kind;
        logic [31:0] pc;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
    } trace_entry_t;

    localparam logic [3:0] TR_BE_FULL = 4'b1111;

endpackage

// File: rtl/trace_fifo.sv
// Dual-push, single-pop circular FIFO of trace entries with show-ahead head.
// push_n selects how many of push0/push1 are written this cycle (push0 first).
module trace_fifo
    import trace_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [1:0]               push_n,
    input  trace_entry_t             push0,
    input  trace_entry_t             push1,
    input  logic                     pop,
    output trace_entry_t             head,
    output logic [$clog2(DEPTH):0]   count,
    output logic [$clog2(DEPTH):0]   free
);

    localparam int AW = $clog2(DEPTH);

    trace_entry_t  mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic          pop_s;

    // A pop on an empty FIFO is ignored so the pointers can never desync.
    assign pop_s = pop && (count_r != '0);

    // A same-cycle pop frees its slot for that cycle's pushes.
    assign free  = (AW+1)'(DEPTH) - count_r + (AW+1)'(pop_s);
    assign count = count_r;
    assign head  = (count_r != '0) ? mem_r[rd_ptr_r] : '0;

    // Storage: write one or two entries at the write pointer, clear on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            if (push_n != 2'd0) begin
                mem_r[wr_ptr_r] <= push0;
            end
            if (push_n == 2'd2) begin
                mem_r[wr_ptr_r + AW'(1)] <= push1;
            end
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            wr_ptr_r <= wr_ptr_r + AW'(push_n);
            rd_ptr_r <= rd_ptr_r + AW'(pop_s);
            count_r  <= count_r + (AW+1)'(push_n) - (AW+1)'(pop_s);
        end
    end

endmodule

// File: rtl/trace_collector.sv
// Snoops the core's GRF (WB) and DM (MEM) write ports, orders same-cycle
// events GRF-first, buffers them and tracks drops when the buffer is full.
module trace_collector
    import trace_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             grf_we,
    input  logic [31:0]      grf_pc,
    input  logic [4:0]       grf_addr,
    input  logic [31:0]      grf_wd,
    input  logic             dm_we,
    input  logic [31:0]      dm_pc,
    input  logic [31:0]      dm_addr,
    input  logic [3:0]       dm_be,
    input  logic [31:0]      dm_wd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_kind,
    output logic [31:0]      out_pc,
    output logic [31:0]      out_addr,
    output logic [3:0]       out_be,
    output logic [31:0]      out_data,
    output logic             overflow,
    output logic [CNT_W-1:0] drop_cnt
);

    localparam int AW = $clog2(DEPTH);

    logic             grf_ev_s;
    logic             dm_ev_s;
    logic             pop_s;
    logic [1:0]       push_n_s;
    logic [1:0]       drop_n_s;
    trace_entry_t     grf_entry_s;
    trace_entry_t     dm_entry_s;
    trace_entry_t     push0_s;
    trace_entry_t     push1_s;
    trace_entry_t     head_s;
    logic [AW:0]      count_s;
    logic [AW:0]      free_s;
    logic [CNT_W:0]   drop_sum_s;
    logic [CNT_W-1:0] drop_cnt_nxt_s;
    logic             overflow_r;
    logic [CNT_W-1:0] drop_cnt_r;

    // Writes to $0 and stores with no lanes enabled are not architectural.
    assign grf_ev_s = grf_we && (grf_addr != 5'd0);
    assign dm_ev_s  = dm_we && (dm_be != 4'd0);

    assign grf_entry_s = '{kind: TR_GRF, pc: grf_pc, addr: {27'd0, grf_addr},
                           be: TR_BE_FULL, data: grf_wd};
    assign dm_entry_s  = '{kind: TR_DM, pc: dm_pc, addr: dm_addr,
                           be: dm_be, data: dm_wd};

    assign out_valid = (count_s != '0);
    assign pop_s     = out_valid && out_ready;

    // Push ordering and drop arbitration against the space left this cycle.
    always_comb begin
        push_n_s = 2'd0;
        drop_n_s = 2'd0;
        push0_s  = grf_entry_s;
        push1_s  = dm_entry_s;
        case ({grf_ev_s, dm_ev_s})
            2'b11: begin
                if (free_s >= (AW+1)'(2)) begin
                    push_n_s = 2'd2;
                end else if (free_s == (AW+1)'(1)) begin
                    push_n_s = 2'd1;
                    drop_n_s = 2'd1;
                end else begin
                    drop_n_s = 2'd2;
                end
            end
            2'b10: begin
                if (free_s != '0) begin
                    push_n_s = 2'd1;
                end else begin
                    drop_n_s = 2'd1;
                end
            end
            2'b01: begin
                push0_s = dm_entry_s;
                if (free_s != '0) begin
                    push_n_s = 2'd1;
                end else begin
                    drop_n_s = 2'd1;
                end
            end
            default: begin
                push_n_s = 2'd0;
                drop_n_s = 2'd0;
            end
        endcase
    end

    // Saturating next value of the drop counter.
    always_comb begin
        drop_sum_s = {1'b0, drop_cnt_r} + (CNT_W+1)'(drop_n_s);
        if (drop_sum_s[CNT_W]) begin
            drop_cnt_nxt_s = '1;
        end else begin
            drop_cnt_nxt_s = drop_sum_s[CNT_W-1:0];
        end
    end

    // Drop counter and sticky overflow flag; both clear only on reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_cnt_r <= '0;
            overflow_r <= 1'b0;
        end else begin
            drop_cnt_r <= drop_cnt_nxt_s;
            if (drop_n_s != 2'd0) begin
                overflow_r <= 1'b1;
            end
        end
    end

    trace_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (reset),
        .push_n (push_n_s),
        .push0  (push0_s),
        .push1  (push1_s),
        .pop    (pop_s),
        .head   (head_s),
        .count  (count_s),
        .free   (free_s)
    );

    assign out_kind = head_s.kind;
    assign out_pc   = head_s.pc;
    assign out_addr = head_s.addr;
    assign out_be   = head_s.be;
    assign out_data = head_s.data;
    assign overflow = overflow_r;
    assign drop_cnt = drop_cnt_r;

endmodule

// File: tb/tb_trace_collector.sv
// Directed bench for trace_collector: a vector table for single-cycle
// behaviour plus hand-written backpressure, overflow, reset and saturation runs.
module tb_trace_collector;
    import trace_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        grf_we;
    logic [31:0] grf_pc;
    logic [4:0]  grf_addr;
    logic [31:0] grf_wd;
    logic        dm_we;
    logic [31:0] dm_pc;
    logic [31:0] dm_addr;
    logic [3:0]  dm_be;
    logic [31:0] dm_wd;
    logic        out_valid;
    logic        out_ready;
    logic        out_kind;
    logic [31:0] out_pc;
    logic [31:0] out_addr;
    logic [3:0]  out_be;
    logic [31:0] out_data;
    logic        overflow;
    logic [15:0] drop_cnt;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    always #5 clk = ~clk;

    trace_collector #(.DEPTH(8), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .grf_we(grf_we), .grf_pc(grf_pc), .grf_addr(grf_addr), .grf_wd(grf_wd),
        .dm_we(dm_we), .dm_pc(dm_pc), .dm_addr(dm_addr), .dm_be(dm_be), .dm_wd(dm_wd),
        .out_valid(out_valid), .out_ready(out_ready), .out_kind(out_kind),
        .out_pc(out_pc), .out_addr(out_addr), .out_be(out_be), .out_data(out_data),
        .overflow(overflow), .drop_cnt(drop_cnt)
    );

    typedef struct {
        logic        gwe;
        logic [4:0]  ga;
        logic [31:0] gpc;
        logic [31:0] gwd;
        logic        dwe;
        logic [31:0] dpc;
        logic [31:0] da;
        logic [3:0]  be;
        logic [31:0] dwd;
        logic        rdy;
        logic        ev;
        logic        ek;
        logic [31:0] epc;
        logic [31:0] ea;
        logic [3:0]  ebe;
        logic [31:0] ed;
        logic [15:0] edrop;
        logic        eovf;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic gwe, input logic [4:0] ga, input logic [31:0] gpc,
                         input logic [31:0] gwd, input logic dwe, input logic [31:0] dpc,
                         input logic [31:0] da, input logic [3:0] be, input logic [31:0] dwd,
                         input logic rdy);
        grf_we = gwe; grf_addr = ga; grf_pc = gpc; grf_wd = gwd;
        dm_we = dwe; dm_pc = dpc; dm_addr = da; dm_be = be; dm_wd = dwd;
        out_ready = rdy;
    endtask

    task automatic idle(input logic rdy);
        drive(1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, rdy);
    endtask

    task automatic grf_only(input logic [4:0] ga, input logic [31:0] gpc, input logic [31:0] gwd,
                            input logic rdy);
        drive(1'b1, ga, gpc, gwd, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, rdy);
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_head(input string tag, input logic v, input logic k, input logic [31:0] pc,
                            input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        chk({tag, ".valid"}, {31'd0, out_valid}, {31'd0, v});
        chk({tag, ".kind"},  {31'd0, out_kind},  {31'd0, k});
        chk({tag, ".pc"},    out_pc, pc);
        chk({tag, ".addr"},  out_addr, a);
        chk({tag, ".be"},    {28'd0, out_be}, {28'd0, be});
        chk({tag, ".data"},  out_data, d);
    endtask

    task automatic chk_drop(input string tag, input logic [15:0] d, input logic o);
        chk({tag, ".drop_cnt"}, {16'd0, drop_cnt}, {16'd0, d});
        chk({tag, ".overflow"}, {31'd0, overflow}, {31'd0, o});
    endtask

    initial begin
        // gwe ga gpc gwd | dwe dpc da be dwd | rdy || ev ek epc ea ebe ed edrop eovf
        vecs[0] = '{1'b1, 5'd8, 32'h3000, 32'h1234, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b1,
                    1'b1, 1'b0, 32'h3000, 32'h8, 4'hF, 32'h1234, 16'd0, 1'b0};
        vecs[1] = '{1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b1,
                    1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 16'd0, 1'b0};
        vecs[2] = '{1'b1, 5'd5, 32'h3004, 32'hAAAA, 1'b1, 32'h3008, 32'h10, 4'b0011, 32'h5555, 1'b1,
                    1'b1, 1'b0, 32'h3004, 32'h5, 4'hF, 32'hAAAA, 16'd0, 1'b0};
        vecs[3] = '{1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b1,
                    1'b1, 1'b1, 32'h3008, 32'h10, 4'b0011, 32'h5555, 16'd0, 1'b0};
        vecs[4] = '{1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b1,
                    1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 16'd0, 1'b0};
        vecs[5] = '{1'b1, 5'd0, 32'h300C, 32'hDEAD, 1'b1, 32'h3010, 32'h20, 4'h0, 32'hBEEF, 1'b1,
                    1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 16'd0, 1'b0};
        vecs[6] = '{1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b1,
                    1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 16'd0, 1'b0};

        // Power-on reset
        reset = 1'b0;
        idle(1'b0);
        cycle();
        cycle();
        chk_head("rst", 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0);
        chk_drop("rst", 16'd0, 1'b0);
        reset = 1'b1;
        cycle();

        // Table: single event, dual event ordering, filtered writes
        for (int i = 0; i < 7; i++) begin
            drive(vecs[i].gwe, vecs[i].ga, vecs[i].gpc, vecs[i].gwd, vecs[i].dwe,
                  vecs[i].dpc, vecs[i].da, vecs[i].be, vecs[i].dwd, vecs[i].rdy);
            cycle();
            chk_head($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ek, vecs[i].epc,
                     vecs[i].ea, vecs[i].ebe, vecs[i].ed);
            chk_drop($sformatf("vec%0d", i), vecs[i].edrop, vecs[i].eovf);
        end

        // Backpressure: fill 8, then GRF+DM both dropped
        for (int k = 0; k < 8; k++) begin
            grf_only(5'(k + 1), 32'h4000 + 32'(4 * k), 32'h100 + 32'(k), 1'b0);
            cycle();
        end
        chk_drop("fill8", 16'd0, 1'b0);
        drive(1'b1, 5'd9, 32'h4020, 32'h109, 1'b1, 32'h4024, 32'h40, 4'hF, 32'h77, 1'b0);
        cycle();
        chk_drop("full_dual", 16'd2, 1'b1);
        idle(1'b1);
        for (int k = 0; k < 8; k++) begin
            chk_head($sformatf("drain%0d", k), 1'b1, 1'b0, 32'h4000 + 32'(4 * k),
                     32'(k + 1), 4'hF, 32'h100 + 32'(k));
            cycle();
        end
        chk({"drain_end", ".valid"}, {31'd0, out_valid}, 32'd0);

        // Full FIFO with a pop frees one slot: GRF kept, DM dropped
        for (int k = 0; k < 8; k++) begin
            grf_only(5'(k + 1), 32'h5000 + 32'(4 * k), 32'h200 + 32'(k), 1'b0);
            cycle();
        end
        drive(1'b1, 5'd20, 32'h6000, 32'hBEEF, 1'b1, 32'h6004, 32'h80, 4'hF, 32'hCAFE, 1'b1);
        cycle();
        chk_drop("pop_dual", 16'd3, 1'b1);
        idle(1'b1);
        for (int k = 1; k < 8; k++) begin
            chk_head($sformatf("drain2_%0d", k), 1'b1, 1'b0, 32'h5000 + 32'(4 * k),
                     32'(k + 1), 4'hF, 32'h200 + 32'(k));
            cycle();
        end
        chk_head("drain2_new", 1'b1, 1'b0, 32'h6000, 32'd20, 4'hF, 32'hBEEF);
        cycle();
        chk({"drain2_end", ".valid"}, {31'd0, out_valid}, 32'd0);

        // Asynchronous reset with 5 entries queued
        for (int k = 0; k < 5; k++) begin
            grf_only(5'(k + 1), 32'h7000 + 32'(4 * k), 32'h300 + 32'(k), 1'b0);
            cycle();
        end
        idle(1'b1);
        chk_head("pre_rst", 1'b1, 1'b0, 32'h7000, 32'd1, 4'hF, 32'h300);
        #2;
        reset = 1'b0;
        #1;
        chk_head("async_rst", 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0);
        chk_drop("async_rst", 16'd0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        cycle();
        chk({"post_rst", ".valid"}, {31'd0, out_valid}, 32'd0);

        // Drop counter saturation
        for (int k = 0; k < 8; k++) begin
            grf_only(5'(k + 1), 32'h8000, 32'h0, 1'b0);
            cycle();
        end
        drive(1'b1, 5'd1, 32'h9000, 32'h1, 1'b1, 32'h9004, 32'h0, 4'h1, 32'h2, 1'b0);
        repeat (32767) cycle();
        chk_drop("sat_m1", 16'hFFFE, 1'b1);
        cycle();
        chk_drop("sat", 16'hFFFF, 1'b1);
        cycle();
        chk_drop("sat_hold", 16'hFFFF, 1'b1);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
